// File: rtl/bank_conflict_scheduler.sv
// Multi-port write front end for the skewed, banked tile buffer.
// Takes a group of up to PORTS (row, column, data) writes per handshake.
// Each lane is mapped to a bank and entry with the skewed mapping.
// Lanes that land on the same bank go out on successive cycles, lowest
// lane index first. The upstream is held off until the group has drained.
//
// There is no explicit state machine. The pending lane mask is the whole
// control state:
//   pending | meaning
//   ------- | --------------------------------------------------------
//   0       | idle, or the last issue of a group is on its way out
//   != 0    | lanes still waiting for a conflict-free bank slot

module bank_conflict_scheduler #(
    parameter  int BANK_COUNT = 32,
    parameter  int TILE_SIZE  = 256,
    parameter  int PORTS      = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int SKEW       = 3,
    localparam int RW         = $clog2(TILE_SIZE),
    localparam int BW         = $clog2(BANK_COUNT),
    localparam int CW         = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PORTS-1:0]                 in_mask,
    input  logic [PORTS*RW-1:0]              in_row,
    input  logic [PORTS*RW-1:0]              in_column,
    input  logic [PORTS*DATA_WIDTH-1:0]      in_data,
    output logic [BANK_COUNT-1:0]            bank_we,
    output logic [BANK_COUNT*RW-1:0]         bank_entry,
    output logic [BANK_COUNT*DATA_WIDTH-1:0] bank_data,
    output logic                             busy,
    output logic [CW-1:0]                    stall_count
);

    // Lane context captured at acceptance. The column is only needed to
    // form the bank, so the bank is stored in its place.
    logic [RW-1:0]         lane_row  [PORTS];
    logic [DATA_WIDTH-1:0] lane_data [PORTS];
    logic [BW-1:0]         lane_bank [PORTS];
    logic [PORTS-1:0]      pending;

    logic [BW-1:0]         in_bank   [PORTS];
    logic [PORTS-1:0]      grant;
    logic [PORTS-1:0]      remaining;
    logic [BANK_COUNT-1:0] bank_used;
    logic                  accept;

    // The skew product is formed at full width. Because BANK_COUNT is a
    // power of two, each modulo reduces to keeping the low BW bits.
    function automatic logic [BW-1:0] map_bank(
        input logic [RW-1:0] row,
        input logic [RW-1:0] col
    );
        logic [RW+31:0] prod;
        logic [RW+BW:0] sum;
        prod = (RW+32)'(row) * (RW+32)'(SKEW);
        sum  = (RW+BW+1)'(col) + (RW+BW+1)'(BW'(prod));
        return BW'(sum);
    endfunction

    // Bank lookup for every incoming lane.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            in_bank[i] = map_bank(in_row[i*RW +: RW], in_column[i*RW +: RW]);
        end
    end

    // Greedy grant: the lowest pending lane wins each bank. Identical
    // addresses therefore resolve last-writer-wins by lane index.
    always_comb begin
        grant     = '0;
        bank_used = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (pending[i] && !bank_used[lane_bank[i]]) begin
                grant[i]               = 1'b1;
                bank_used[lane_bank[i]] = 1'b1;
            end
        end
    end

    assign remaining = pending & ~grant;

    // Ready is asserted during the final issue of a group as well as when
    // idle. This lets conflict-free groups stream at one per cycle.
    assign in_ready  = rst_n && (remaining == '0);
    assign accept    = in_valid && in_ready;
    assign busy      = (pending != '0);

    // Capture a new group on acceptance; otherwise retire granted lanes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            for (int i = 0; i < PORTS; i++) begin
                lane_row[i]  <= '0;
                lane_data[i] <= '0;
                lane_bank[i] <= '0;
            end
        end else if (accept) begin
            pending <= in_mask;
            for (int i = 0; i < PORTS; i++) begin
                lane_row[i]  <= in_row[i*RW +: RW];
                lane_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                lane_bank[i] <= in_bank[i];
            end
        end else begin
            pending <= remaining;
        end
    end

    // Registered bank write port. Strobes last one cycle. Entry and data of
    // idle banks keep their last written values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_we    <= '0;
            bank_entry <= '0;
            bank_data  <= '0;
        end else begin
            bank_we <= '0;
            for (int i = 0; i < PORTS; i++) begin
                if (grant[i]) begin
                    bank_we[lane_bank[i]]                                  <= 1'b1;
                    bank_entry[int'(lane_bank[i])*RW +: RW]                 <= lane_row[i];
                    bank_data[int'(lane_bank[i])*DATA_WIDTH +: DATA_WIDTH] <= lane_data[i];
                end
            end
        end
    end

    // Count issue cycles that leave lanes behind; saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if ((pending != '0) && (remaining != '0) && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bank_conflict_scheduler.sv
module tb_bank_conflict_scheduler;

    localparam int BC   = 32;
    localparam int RW   = 8;
    localparam int P    = 4;
    localparam int DW   = 16;
    localparam int SK   = 3;
    localparam int CW   = 32;
    localparam int MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [P-1:0]      in_mask;
    logic [P*RW-1:0]   in_row;
    logic [P*RW-1:0]   in_column;
    logic [P*DW-1:0]   in_data;
    logic [BC-1:0]     bank_we;
    logic [BC*RW-1:0]  bank_entry;
    logic [BC*DW-1:0]  bank_data;
    logic              busy;
    logic [CW-1:0]     stall_count;

    always #5 clk = ~clk;

    bank_conflict_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mask     (in_mask),
        .in_row      (in_row),
        .in_column   (in_column),
        .in_data     (in_data),
        .bank_we     (bank_we),
        .bank_entry  (bank_entry),
        .bank_data   (bank_data),
        .busy        (busy),
        .stall_count (stall_count)
    );

    // Stimulus for the next step.
    logic         d_valid;
    logic [P-1:0] d_mask;
    int           d_row  [P];
    int           d_col  [P];
    int           d_data [P];

    // Reference model: a per-edge schedule of expected bank writes.
    int            cyc;
    int            next_accept;
    int            busy_until;
    logic [BC-1:0] s_we    [MAXC];
    logic [RW-1:0] s_entry [MAXC][BC];
    logic [DW-1:0] s_data  [MAXC][BC];
    bit            s_stall [MAXC];
    logic [RW-1:0] m_entry [BC];
    logic [DW-1:0] m_data  [BC];
    logic [BC-1:0] m_we;
    logic [CW-1:0] m_stall;
    bit            last_acc;
    bit            last_ready;

    int checks = 0;
    int errors = 0;

    function automatic int ref_bank(int row, int col);
        return (col + ((row * SK) % BC)) % BC;
    endfunction

    task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < MAXC; c++) begin
            s_we[c]    = '0;
            s_stall[c] = 1'b0;
        end
        for (int b = 0; b < BC; b++) begin
            m_entry[b] = '0;
            m_data[b]  = '0;
        end
        m_stall     = '0;
        next_accept = 0;
        busy_until  = -1;
    endtask

    // One clock: drive, check handshake, update model, check outputs.
    task automatic step();
        bit               ready_m;
        bit               busy_m;
        int               rank [P];
        int               len;
        int               b;
        int               t;
        logic [BC*RW-1:0] e_entry;
        logic [BC*DW-1:0] e_data;

        @(negedge clk);
        in_valid = d_valid;
        in_mask  = d_mask;
        for (int i = 0; i < P; i++) begin
            in_row[i*RW +: RW]    = d_row[i][RW-1:0];
            in_column[i*RW +: RW] = d_col[i][RW-1:0];
            in_data[i*DW +: DW]   = d_data[i][DW-1:0];
        end
        #1;
        ready_m = rst_n && (cyc >= next_accept);
        busy_m  = (cyc <= busy_until);
        check("in_ready", 512'(in_ready), 512'(ready_m));
        check("busy", 512'(busy), 512'(busy_m));
        last_ready = ready_m;
        last_acc   = d_valid && ready_m;

        if (last_acc) begin
            // Each lane issues after every lower active lane on its bank.
            len = 0;
            for (int i = 0; i < P; i++) begin
                rank[i] = 0;
                if (d_mask[i]) begin
                    for (int j = 0; j < i; j++)
                        if (d_mask[j] && ref_bank(d_row[j], d_col[j]) == ref_bank(d_row[i], d_col[i]))
                            rank[i]++;
                    if (rank[i] + 1 > len) len = rank[i] + 1;
                    b = ref_bank(d_row[i], d_col[i]);
                    t = cyc + 1 + rank[i];
                    s_we[t][b]    = 1'b1;
                    s_entry[t][b] = d_row[i][RW-1:0];
                    s_data[t][b]  = d_data[i][DW-1:0];
                end
            end
            for (int k = 0; k < len - 1; k++) s_stall[cyc + 1 + k] = 1'b1;
            next_accept = cyc + ((len > 0) ? len : 1);
            busy_until  = cyc + len;
        end

        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
            m_we = '0;
        end else begin
            m_we = s_we[cyc];
            for (int k = 0; k < BC; k++) begin
                if (m_we[k]) begin
                    m_entry[k] = s_entry[cyc][k];
                    m_data[k]  = s_data[cyc][k];
                end
            end
            if (s_stall[cyc] && m_stall != '1) m_stall = m_stall + 1'b1;
        end
        for (int k = 0; k < BC; k++) begin
            e_entry[k*RW +: RW] = m_entry[k];
            e_data[k*DW +: DW]  = m_data[k];
        end
        check("bank_we", 512'(bank_we), 512'(m_we));
        check("bank_entry", 512'(bank_entry), 512'(e_entry));
        check("bank_data", 512'(bank_data), 512'(e_data));
        check("stall_count", 512'(stall_count), 512'(m_stall));
        cyc++;
    endtask

    task automatic set_lane(int i, int row, int col, int data);
        d_row[i]  = row;
        d_col[i]  = col;
        d_data[i] = data;
    endtask

    initial begin
        int accepts;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_row    = '0;
        in_column = '0;
        in_data   = '0;
        d_valid   = 1'b0;
        d_mask    = '0;
        for (int i = 0; i < P; i++) set_lane(i, 0, 0, 0);
        cyc = 0;
        model_reset();

        step();
        step();
        rst_n = 1'b1;
        step();

        // Conflict-free group: banks 0..3 one cycle after acceptance.
        d_valid = 1'b1;
        d_mask  = 4'b1111;
        for (int i = 0; i < P; i++) set_lane(i, 0, i, 'hA0 + i);
        step();
        check("cf_accept", 512'(last_acc), 512'(1));
        d_valid = 1'b0;
        step();
        check("cf_we", 512'(bank_we), 512'(32'h0000_000F));
        check("cf_data3", 512'(bank_data[3*DW +: DW]), 512'(16'h00A3));

        // Skew conflict: (0,0) and (1,29) both land on bank 0.
        d_valid = 1'b1;
        d_mask  = 4'b0011;
        set_lane(0, 0, 0, 'h11);
        set_lane(1, 1, 29, 'h22);
        step();
        d_valid = 1'b0;
        step();
        check("skew_we0", 512'(bank_we), 512'(32'h1));
        check("skew_data0", 512'(bank_data[DW-1:0]), 512'(16'h0011));
        step();
        check("skew_entry1", 512'(bank_entry[RW-1:0]), 512'(8'h01));
        check("skew_data1", 512'(bank_data[DW-1:0]), 512'(16'h0022));
        check("skew_stall", 512'(stall_count), 512'(1));

        // Full collision: four identical addresses, lane 3 wins.
        d_valid = 1'b1;
        d_mask  = 4'b1111;
        for (int i = 0; i < P; i++) set_lane(i, 0, 0, 'hB0 + i);
        step();
        d_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("full_data", 512'(bank_data[DW-1:0]), 512'(16'h00B3));
        check("full_stall", 512'(stall_count), 512'(4));

        // Back-to-back conflict-free groups with valid held high.
        accepts = 0;
        d_valid = 1'b1;
        d_mask  = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < P; i++) set_lane(i, g, i, 'h100 * g + i);
            step();
            if (last_acc) accepts++;
        end
        check("b2b_accepts", 512'(accepts), 512'(8));
        d_valid = 1'b0;
        step();

        // Reset during issue 1 of a full collision.
        d_valid = 1'b1;
        d_mask  = 4'b1111;
        for (int i = 0; i < P; i++) set_lane(i, 0, 0, 'hC0 + i);
        step();
        d_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("rst_we", 512'(bank_we), 512'(0));
        check("rst_stall", 512'(stall_count), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        rst_n   = 1'b1;
        d_valid = 1'b1;
        for (int i = 0; i < P; i++) set_lane(i, 5, 8 + i, 'hD0 + i);
        step();
        check("rst_reaccept", 512'(last_acc), 512'(1));
        d_valid = 1'b0;
        step();

        // Empty mask group.
        d_valid = 1'b1;
        d_mask  = 4'b0000;
        step();
        check("mask0_accept", 512'(last_acc), 512'(1));
        d_valid = 1'b0;
        step();
        check("mask0_we", 512'(bank_we), 512'(0));

        // Corner address: row 255, column 255 maps to bank 28.
        d_valid = 1'b1;
        d_mask  = 4'b0001;
        set_lane(0, 255, 255, 'hCAFE);
        step();
        d_valid = 1'b0;
        step();
        check("corner_we", 512'(bank_we), 512'(32'h1000_0000));
        check("corner_entry", 512'(bank_entry[28*RW +: RW]), 512'(8'hFF));
        check("corner_data", 512'(bank_data[28*DW +: DW]), 512'(16'hCAFE));

        // Randomized traffic with biased collisions and occasional resets.
        for (int n = 0; n < 400; n++) begin
            if (!(d_valid && !last_ready)) begin
                d_valid = ($urandom_range(0, 9) < 8);
                d_mask  = P'($urandom_range(0, 15));
                for (int i = 0; i < P; i++) begin
                    if ($urandom_range(0, 1) == 1)
                        set_lane(i, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
                    else
                        set_lane(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
                end
            end
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n   = 1'b1;
        d_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
